regfile_dumper: RTL and testbench
=================================

// Module: regfile_dumper
// PURPOSE
//  Debug/trace reader for the integer register file. On a start pulse it walks
//  the register file through one read port, from the first index to the last.
//  It streams each register value out over a valid/ready interface, tagged with
//  its index, with a last flag on the final word. It sits beside the datapath and
//  borrows read port 1 while busy; the core must not use that port when busy=1.
// PARAMETERS
//  XLEN          32  register width in bits
//  REG_ADDR_LEN  5   register address width
//  NUM_REGS      32  registers walked; must be <= 2**REG_ADDR_LEN
//  SKIP_ZERO     1   1: start at x1, x0 not emitted; 0: start at x0 (value 0)
// PORTS
//  clk         in   1             rising-edge clock
//  reset_n     in   1             asynchronous active-low reset
//  start       in   1             1-cycle request to begin a dump
//  abort       in   1             cancel the dump in progress
//  ra          out  REG_ADDR_LEN  read address to regfile read port 1
//  rd          in   XLEN          combinational read data for ra, same cycle
//  dump_valid  out  1             dump_data/idx/last hold a valid word
//  dump_ready  in   1             consumer accepts the word this cycle
//  dump_data   out  XLEN          register value
//  dump_idx    out  REG_ADDR_LEN  register index of dump_data
//  dump_last   out  1             word is the final register
//  busy        out  1             walk in progress; regfile port 1 is owned
//  done        out  1             1-cycle pulse after the last word is accepted
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; ra=0; dump_valid=0; dump_data=0.
//    Also on reset: dump_idx=0, dump_last=0, busy=0, done=0.
//  - All outputs are registered. Define FIRST = SKIP_ZERO ? 1 : 0.
//  - States IDLE, READ, HOLD, DONE. busy=1 in READ and HOLD only.
//  - IDLE: start=1 -> ra<=FIRST, go to READ. start is ignored in any other state.
//  - READ: rd is valid for ra. Capture into the output registers:
//    dump_data<=rd, dump_idx<=ra, dump_last<=(ra==NUM_REGS-1), dump_valid<=1.
//    Then go to HOLD.
//  - HOLD: outputs are stable while dump_valid=1 and dump_ready=0.
//    On dump_valid & dump_ready, dump_valid<=0, then:
//    - if dump_last, go to DONE;
//    - else ra<=ra+1 and go to READ.
//  - DONE: done=1 for exactly one cycle, then IDLE. dump_last is cleared.
//  - Throughput: one word per 2 cycles with dump_ready held at 1.
//    A full dump with SKIP_ZERO=1 and NUM_REGS=32 spans 62 cycles from the first
//    READ to the DONE state.
//  - Data is a per-word snapshot taken at that word's READ cycle.
//    A core write to register k before k's READ cycle is visible in the dump.
//    A write after that cycle is not. No cross-register consistency is provided.
//  - ra never exceeds NUM_REGS-1 and never wraps. Index arithmetic is
//    REG_ADDR_LEN bits wide.
//  - abort=1 in READ, HOLD or DONE -> next cycle: IDLE, dump_valid=0,
//    dump_last=0, busy=0, done=0. abort has priority over dump_ready and start.
//    abort in IDLE has no effect.
//  - start and abort in the same cycle in IDLE: abort wins and no dump starts.
//  - Reset asserted mid-dump: outputs take reset values immediately, without
//    waiting for a clock edge.
// TESTING
//  1. Preload x1..x31 = 0x100+i, SKIP_ZERO=1, dump_ready=1, pulse start ->
//     31 words idx 1..31, data 0x101..0x11F. dump_last only on idx 31.
//     done pulses once, 2 cycles after the idx 31 handshake.
//  2. Backpressure: dump_ready low for 5 cycles on word idx 4 ->
//     dump_valid, dump_data=0x104 and dump_idx=4 are held unchanged.
//     Idx 5 is emitted only after the handshake.
//  3. Abort while HOLD at idx 10 -> next cycle dump_valid=0 and busy=0, no done.
//     A new start then restarts at idx 1.
//  4. Core writes x20=0xDEAD while the dump is at idx 5 -> the idx 20 word
//     carries 0xDEAD. A write to x3 at the same time leaves the idx 3 word at
//     0x103.
//  5. SKIP_ZERO=0 -> first word is idx 0 with data 0; 32 words in total.
//     A start pulse while busy has no effect on the sequence.
//  6. Drop reset_n between clock edges while dump_valid=1 -> dump_valid and
//     busy fall without a clock edge. After release, outputs are idle until
//     the next start.

Source files
------------

// File: rtl/regfile_dumper.sv
// regfile_dumper: debug/trace reader that walks the integer register file
// through read port 1 and streams each register value out over a valid/ready
// interface, tagged with its index and a last flag on the final word.
// The done pulse is registered from the DONE state, so it appears in the
// cycle after DONE (two cycles after the final handshake cycle).
module regfile_dumper #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int NUM_REGS     = 32,
    parameter int SKIP_ZERO    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [REG_ADDR_LEN-1:0] ra,
    input  logic [XLEN-1:0]         rd,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [XLEN-1:0]         dump_data,
    output logic [REG_ADDR_LEN-1:0] dump_idx,
    output logic                    dump_last,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [REG_ADDR_LEN-1:0] FIRST_IDX =
        (SKIP_ZERO != 0) ? REG_ADDR_LEN'(1) : '0;
    localparam logic [REG_ADDR_LEN-1:0] LAST_IDX = REG_ADDR_LEN'(NUM_REGS - 1);

    logic [1:0]              state_q, state_d;
    logic [REG_ADDR_LEN-1:0] ra_q, ra_d;
    logic [XLEN-1:0]         data_q, data_d;
    logic [REG_ADDR_LEN-1:0] idx_q, idx_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next-state logic: walk READ/HOLD pairs, abort returns to IDLE at once
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        ra_d    = FIRST_IDX;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    data_d  = rd;
                    idx_d   = ra_q;
                    last_d  = (ra_q == LAST_IDX);
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (valid_q && dump_ready) begin
                        valid_d = 1'b0;
                        if (last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            ra_d    = ra_q + REG_ADDR_LEN'(1);
                            state_d = ST_READ;
                        end
                    end
                end
                default: begin
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_READ) || (state_d == ST_HOLD);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ra         = ra_q;
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_idx   = idx_q;
    assign dump_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: randomized self-checking bench for regfile_dumper.
// Two instances share one register file model: dut_a skips x0, dut_b does not.
module tb_regfile_dumper;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic        use_b = 1'b0;

    logic [31:0] regs [N];
    logic [31:0] got_data [N];

    logic [4:0]  ra_a, ra_b, idx_a, idx_b;
    logic [31:0] rd_a, rd_b, data_a, data_b;
    logic        valid_a, valid_b, last_a, last_b, busy_a, busy_b, done_a, done_b;
    logic        start_a, start_b, abort_a, abort_b;

    logic [4:0]  v_ra, v_idx;
    logic [31:0] v_data;
    logic        v_valid, v_last, v_busy, v_done;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // Free-running clock
    always #5 clk = ~clk;

    // Register file read ports and per-instance input gating
    assign rd_a    = regs[ra_a];
    assign rd_b    = regs[ra_b];
    assign start_a = start & ~use_b;
    assign start_b = start & use_b;
    assign abort_a = abort & ~use_b;
    assign abort_b = abort & use_b;

    // View of whichever instance is under test
    assign v_ra    = use_b ? ra_b    : ra_a;
    assign v_idx   = use_b ? idx_b   : idx_a;
    assign v_data  = use_b ? data_b  : data_a;
    assign v_valid = use_b ? valid_b : valid_a;
    assign v_last  = use_b ? last_b  : last_a;
    assign v_busy  = use_b ? busy_b  : busy_a;
    assign v_done  = use_b ? done_b  : done_a;

    regfile_dumper #(.XLEN(32), .REG_ADDR_LEN(5), .NUM_REGS(N), .SKIP_ZERO(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .ra(ra_a), .rd(rd_a), .dump_valid(valid_a), .dump_ready(ready),
        .dump_data(data_a), .dump_idx(idx_a), .dump_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    regfile_dumper #(.XLEN(32), .REG_ADDR_LEN(5), .NUM_REGS(N), .SKIP_ZERO(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .ra(ra_b), .rd(rd_b), .dump_valid(valid_b), .dump_ready(ready),
        .dump_data(data_b), .dump_idx(idx_b), .dump_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tick_no++;
    endtask

    task automatic preload();
        regs[0] = 32'h0;
        for (int i = 1; i < N; i++) regs[i] = 32'h100 + i;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, v_valid, 0);
        checkOutput({tag, "_busy"}, v_busy, 0);
        checkOutput({tag, "_done"}, v_done, 0);
        checkOutput({tag, "_last"}, v_last, 0);
    endtask

    // One dump against the reference model: words in index order, each word's
    // data equal to the register value at the moment the word is presented,
    // held stable until accepted, one gap cycle between words, done pulse two
    // cycles after the last acceptance.
    // abort_kind: 0 none, 1 abort while presenting abort_idx, 2 abort in the
    // read cycle of abort_idx, 3 abort in the cycle after the last handshake.
    task automatic applyStimulus(input bit sel_b, input int pct, input int bp_idx,
                                 input int abort_kind, input int abort_idx,
                                 input bit rand_writes, input bit write_demo,
                                 input bit extra_start, input bit check_span);
        int first, exp_idx, countdown, bp_left, nwords, seen, first_read_tick;
        bit holding, finished, aborted, hs, abort_was;
        logic [31:0] held;
        use_b = sel_b;
        first = sel_b ? 0 : 1;
        nwords = N - first;
        start = 1'b1;
        tick();
        start = 1'b0;
        first_read_tick = tick_no;
        exp_idx = first;
        countdown = 1;
        bp_left = 5;
        seen = 0;
        holding = 0;
        finished = 0;
        aborted = 0;
        held = '0;
        for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
            if (holding) begin
                checkOutput("hold_valid", v_valid, 1);
                checkOutput("hold_data", v_data, held);
                checkOutput("hold_idx", v_idx, exp_idx);
                checkOutput("hold_last", v_last, exp_idx == N - 1);
            end else if (countdown == 0) begin
                checkOutput("word_valid", v_valid, 1);
                checkOutput("word_idx", v_idx, exp_idx);
                checkOutput("word_data", v_data, regs[exp_idx]);
                checkOutput("word_last", v_last, exp_idx == N - 1);
                checkOutput("word_busy", v_busy, 1);
                held = regs[exp_idx];
                got_data[exp_idx] = v_data;
                holding = 1;
                seen++;
                if (write_demo && exp_idx == 5) begin
                    regs[20] = 32'hDEAD;
                    regs[3]  = 32'hDEAD;
                end
            end else begin
                checkOutput("gap_valid", v_valid, 0);
                checkOutput("gap_busy", v_busy, 1);
                countdown--;
            end

            ready = 1'b0;
            if (holding) begin
                if (abort_kind == 1 && exp_idx == abort_idx) abort = 1'b1;
                else if (exp_idx == bp_idx && bp_left > 0) bp_left--;
                else ready = (pct >= 100) || ($urandom_range(0, 99) < pct);
            end else if (abort_kind == 2 && exp_idx == abort_idx) begin
                abort = 1'b1;
            end
            if (extra_start && cyc == 7) start = 1'b1;
            if (rand_writes && $urandom_range(0, 3) == 0)
                regs[$urandom_range(1, N - 1)] = $urandom;

            hs = holding && ready;
            abort_was = abort;
            tick();
            start = 1'b0;
            abort = 1'b0;
            ready = 1'b0;
            if (abort_was) begin
                aborted = 1;
            end else if (hs) begin
                holding = 0;
                if (exp_idx == N - 1) finished = 1;
                else begin
                    exp_idx++;
                    countdown = 1;
                end
            end
        end

        if (aborted) begin
            checkIdle("abort_next");
            tick();
            checkIdle("abort_after");
        end else if (finished) begin
            checkOutput("word_count", seen, nwords);
            checkOutput("end_valid", v_valid, 0);
            checkOutput("end_busy", v_busy, 0);
            checkOutput("end_done_early", v_done, 0);
            if (check_span) checkOutput("span_cycles", tick_no - first_read_tick, 2 * nwords);
            if (abort_kind == 3) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checkIdle("abort_done");
                tick();
                checkIdle("abort_done_after");
            end else begin
                tick();
                checkOutput("done_pulse", v_done, 1);
                checkOutput("done_busy", v_busy, 0);
                checkOutput("done_valid", v_valid, 0);
                checkOutput("done_last", v_last, 0);
                tick();
                checkIdle("after_done");
            end
        end else begin
            checkOutput("dump_timeout", 0, 1);
        end
    endtask

    initial begin
        preload();
        for (int i = 0; i < N; i++) got_data[i] = '0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_valid", v_valid, 0);
        checkOutput("rst_data", v_data, 0);
        checkOutput("rst_idx", v_idx, 0);
        checkOutput("rst_ra", v_ra, 0);
        checkIdle("rst");
        reset_n = 1'b1;
        tick();
        checkIdle("post_rst");

        // Full dump, ready held high, cycle span checked
        applyStimulus(0, 100, -1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < N; i++) checkOutput("full_data", got_data[i], 32'h100 + i);

        // Backpressure on idx 4
        applyStimulus(0, 100, 4, 0, 0, 0, 0, 0, 0);
        checkOutput("bp_data4", got_data[4], 32'h104);

        // Abort while presenting idx 10, then a fresh dump from idx 1
        applyStimulus(0, 100, -1, 1, 10, 0, 0, 0, 0);
        applyStimulus(0, 100, -1, 0, 0, 0, 0, 0, 0);

        // Core writes during the dump
        applyStimulus(0, 100, -1, 0, 0, 0, 1, 0, 0);
        checkOutput("write_x20", got_data[20], 32'hDEAD);
        checkOutput("write_x3", got_data[3], 32'h103);
        preload();

        // x0 included, extra start while busy ignored
        applyStimulus(1, 100, -1, 0, 0, 0, 0, 1, 1);
        checkOutput("x0_data", got_data[0], 0);
        use_b = 1'b0;

        // start and abort together in IDLE: no dump
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkIdle("start_abort");
        tick();
        checkIdle("start_abort_after");

        // Abort in the read cycle and in the DONE cycle
        applyStimulus(0, 100, -1, 2, 7, 0, 0, 0, 0);
        applyStimulus(0, 100, -1, 3, 0, 0, 0, 0, 0);

        // Randomized ready, register writes and aborts
        for (int r = 0; r < 6; r++) begin
            applyStimulus(r[0], $urandom_range(30, 90), -1, $urandom_range(0, 2),
                          $urandom_range(1, N - 1), 1, 0, r[1], 0);
        end
        use_b = 1'b0;
        preload();

        // Asynchronous reset mid-dump
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("pre_rst_valid", v_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_valid", v_valid, 0);
        checkOutput("async_busy", v_busy, 0);
        checkOutput("async_data", v_data, 0);
        checkOutput("async_idx", v_idx, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIdle("rst_release");
        end
        applyStimulus(0, 100, -1, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
